// File: rtl/hex_step_counter_pkg.sv
// Shared types and constants for the hex step counter.
// State encoding and the hex digit segment patterns.
package hex_step_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Active-high {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_step_counter_seg7.sv
// Hex digit to active-high 7-segment pattern.
// Purely combinational; the caller registers it.
module hex_to_seg7
  import hex_step_counter_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[hex];

endmodule

// File: rtl/hex_step_counter.sv
// Button-driven hex counter with hold auto-repeat.
// Drives a registered 7-segment pattern of the count.
module hex_step_counter
  import hex_step_counter_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 12000000,
  parameter int HOLD_TIME_MS   = 500,
  parameter int REPEAT_TIME_MS = 100,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_clr,
  output logic [3:0] count,
  output logic [6:0] seg,
  output logic       step_tick,
  output logic       wrap_tick
);

  localparam longint HOLD_L =
    longint'(CLK_FREQ_HZ) * longint'(HOLD_TIME_MS) / 1000;
  localparam longint REP_L =
    longint'(CLK_FREQ_HZ) * longint'(REPEAT_TIME_MS) / 1000;
  localparam int HOLD_CNT   = int'(HOLD_L);
  localparam int REPEAT_CNT = int'(REP_L);
  localparam int MAX_CNT    =
    (HOLD_CNT > REPEAT_CNT) ? HOLD_CNT : REPEAT_CNT;
  localparam int TW = $clog2(MAX_CNT + 1);

  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CNT - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CNT - 1);
  localparam logic [6:0] SEG_RST =
    SEG_ACTIVE_LOW ? ~SEG_LUT[0] : SEG_LUT[0];

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    count_d;
  logic          dir_q, dir_d;
  logic          prev_up_q, prev_dn_q;
  logic          rise_up, rise_dn, held;
  logic          do_step, step_dn, wrap_d;
  logic [6:0]    seg_pat;

  assign rise_up = btn_up & ~prev_up_q;
  assign rise_dn = btn_down & ~prev_dn_q;
  assign held    = dir_q ? btn_down : btn_up;

  // Next state, timer and step request of the press/hold FSM.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    do_step = 1'b0;
    step_dn = dir_q;
    if (btn_clr) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise_up ^ rise_dn) begin
            do_step = 1'b1;
            step_dn = rise_dn;
            dir_d   = rise_dn;
            timer_d = '0;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!held) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else if (timer_q == HOLD_LAST) begin
            do_step = 1'b1;
            timer_d = '0;
            state_d = ST_REPEAT;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!held) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else if (timer_q == REP_LAST) begin
            do_step = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Modulo-16 count update with wrap detection.
  always_comb begin
    count_d = count;
    wrap_d  = 1'b0;
    if (btn_clr) begin
      count_d = 4'h0;
    end else if (do_step) begin
      if (step_dn) begin
        count_d = count - 4'h1;
        wrap_d  = (count == 4'h0);
      end else begin
        count_d = count + 4'h1;
        wrap_d  = (count == 4'hF);
      end
    end
  end

  // Decode the next count so seg lands with count.
  hex_to_seg7 u_seg (
    .hex (count_d),
    .seg (seg_pat)
  );

  // All state and outputs registered together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      dir_q     <= 1'b0;
      prev_up_q <= 1'b1;
      prev_dn_q <= 1'b1;
      count     <= 4'h0;
      seg       <= SEG_RST;
      step_tick <= 1'b0;
      wrap_tick <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      dir_q     <= dir_d;
      prev_up_q <= btn_up;
      prev_dn_q <= btn_down;
      count     <= count_d;
      seg       <= SEG_ACTIVE_LOW ? ~seg_pat : seg_pat;
      step_tick <= do_step & ~btn_clr;
      wrap_tick <= wrap_d & ~btn_clr;
    end
  end

endmodule

// File: tb/tb_hex_step_counter.sv
// Randomized and directed bench for hex_step_counter.
// Two DUTs share inputs: active-high and active-low seg.
module tb_hex_step_counter;

  localparam int HOLD = 5;
  localparam int REP  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] count, count_b;
  logic [6:0] seg, seg_b;
  logic       step_tick, wrap_tick, step_b, wrap_b;

  int tests = 0;
  int fails = 0;

  logic [6:0] segtab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  hex_step_counter #(
    .CLK_FREQ_HZ(1000), .HOLD_TIME_MS(5),
    .REPEAT_TIME_MS(2), .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up),
    .btn_down(btn_down), .btn_clr(btn_clr),
    .count(count), .seg(seg),
    .step_tick(step_tick), .wrap_tick(wrap_tick)
  );

  hex_step_counter #(
    .CLK_FREQ_HZ(1000), .HOLD_TIME_MS(5),
    .REPEAT_TIME_MS(2), .SEG_ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up),
    .btn_down(btn_down), .btn_clr(btn_clr),
    .count(count_b), .seg(seg_b),
    .step_tick(step_b), .wrap_tick(wrap_b)
  );

  always #5 clk = ~clk;

  // Behavioural model: age = cycles since the press step.
  int   m_count = 0;
  bit   m_pu = 1, m_pd = 1;
  int   m_act = 0;
  int   m_age = 0;
  bit   m_step = 0, m_wrap = 0;
  bit   m_valid = 0;

  always @(posedge clk) begin
    bit ru, rd, hd, st, dn;
    st = 0;
    dn = 0;
    if (!rst_n) begin
      m_count = 0;
      m_pu = 1;
      m_pd = 1;
      m_act = 0;
      m_valid = 1;
    end else begin
      ru = btn_up & ~m_pu;
      rd = btn_down & ~m_pd;
      m_pu = btn_up;
      m_pd = btn_down;
      if (btn_clr) begin
        m_count = 0;
        m_act = 0;
      end else if (m_act != 0) begin
        hd = (m_act == 1) ? btn_up : btn_down;
        if (!hd) m_act = 0;
        else begin
          m_age++;
          if (m_age == HOLD ||
              (m_age > HOLD && (m_age - HOLD) % REP == 0))
            st = 1;
          dn = (m_act == 2);
        end
      end else if (ru != rd) begin
        st = 1;
        dn = rd;
        m_act = rd ? 2 : 1;
        m_age = 0;
      end
    end
    m_wrap = 0;
    if (st) begin
      m_wrap = dn ? (m_count == 0) : (m_count == 15);
      m_count = dn ? (m_count + 15) % 16 : (m_count + 1) % 16;
    end
    m_step = st;
  end

  // Every-cycle comparison of both DUTs with the model.
  always @(negedge clk) begin
    logic [6:0] es;
    if (m_valid) begin
      es = segtab[m_count];
      tests++;
      if (count !== 4'(m_count) || seg !== es ||
          step_tick !== m_step || wrap_tick !== m_wrap ||
          count_b !== 4'(m_count) || seg_b !== ~es ||
          step_b !== m_step || wrap_b !== m_wrap) begin
        fails++;
        $display("FAIL model t=%0t got c=%h s=%h st=%b w=%b sb=%h want c=%h s=%h st=%b w=%b",
                 $time, count, seg, step_tick, wrap_tick,
                 seg_b, m_count[3:0], es, m_step, m_wrap);
      end
    end
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear();
    btn_clr = 1;
    cyc(1);
    btn_clr = 0;
    cyc(1);
  endtask

  task automatic tap_up(input int n);
    for (int i = 0; i < n; i++) begin
      btn_up = 1;
      cyc(1);
      btn_up = 0;
      cyc(1);
    end
  endtask

  initial begin
    // 1: held through reset release
    btn_up = 1;
    cyc(2);
    chk("rst_seg", seg, 7'h3F);
    chk("rst_seg_al", seg_b, 7'h40);
    chk("rst_step", step_tick, 0);
    rst_n = 1;
    cyc(20);
    chk("held_cnt", count, 0);
    chk("held_seg", seg, 7'h3F);
    btn_up = 0;
    cyc(1);
    btn_up = 1;
    cyc(1);
    chk("press_cnt", count, 1);
    chk("press_seg", seg, 7'h06);
    btn_up = 0;
    cyc(1);

    // 2: sixteen short presses
    clear();
    for (int i = 0; i < 16; i++) begin
      btn_up = 1;
      cyc(1);
      chk("tap_cnt", count, (i + 1) % 16);
      if (i == 15) begin
        chk("tap_wrap", wrap_tick, 1);
        chk("tap_step", step_tick, 1);
        chk("tap_seg", seg, 7'h3F);
      end
      cyc(2);
      btn_up = 0;
      cyc(1);
    end

    // 3: down hold from 0
    btn_down = 1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (k == 1) begin
        chk("dn_f", count, 4'hF);
        chk("dn_wrap", wrap_tick, 1);
      end
      if (k == 6) chk("dn_e", count, 4'hE);
      if (k == 8) chk("dn_d", count, 4'hD);
      if (k == 10) chk("dn_c", count, 4'hC);
      if (k == 12) chk("dn_b", count, 4'hB);
    end
    btn_down = 0;
    cyc(1);

    // 4: simultaneous rise, then opposite ignored
    btn_up = 1;
    btn_down = 1;
    cyc(1);
    chk("both_step", step_tick, 0);
    chk("both_cnt", count, 4'hB);
    btn_up = 0;
    btn_down = 0;
    cyc(1);
    btn_up = 1;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (k == 6) btn_down = 1;
    end
    chk("opp_cnt", count, 4'hF);
    btn_up = 0;
    btn_down = 0;
    cyc(1);

    // 5: clear beats a rising edge
    clear();
    tap_up(7);
    chk("seven", count, 7);
    btn_up = 1;
    btn_clr = 1;
    cyc(1);
    chk("clr_cnt", count, 0);
    chk("clr_step", step_tick, 0);
    btn_clr = 0;
    cyc(4);
    chk("clr_held", count, 0);
    btn_up = 0;
    cyc(1);

    // 6: active-low seg at 8
    tap_up(8);
    chk("al_eight", seg_b, 7'h00);

    // random phase
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(11) == 0) btn_up = ~btn_up;
      if ($urandom_range(11) == 0) btn_down = ~btn_down;
      btn_clr = ($urandom_range(59) == 0);
      rst_n = ($urandom_range(499) != 0);
    end
    rst_n = 1;
    btn_clr = 0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
